input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, is the number of consecutive pixel_clk cycles a synchronized input must differ from its debounced state before that state flips; legal range 1..2^20.
REQ-002 Parameter FIRE_REPEAT_FRAMES, default 15, is the number of frames between auto-repeat fire pulses while fire is held; 0 disables auto-repeat.
REQ-003 pixel_clk  input  1  sole clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fsync  input  1  one-cycle frame-start pulse from the HDMI timing stage.
REQ-006 btn_raw  input  4  raw asynchronous buttons: [0] right, [1] left, [2] fire, [3] ready_up.
REQ-007 right_move  output  1  frame-stable right command for the paddle.
REQ-008 left_move  output  1  frame-stable left command for the paddle.
REQ-009 fire_pulse  output  1  one-cycle bullet fire request, frame-aligned.
REQ-010 ready_up_pulse  output  1  one-cycle ready-up request for the game state machine.
REQ-011 btn_db  output  4  debounced button states, for debug LEDs.

Function
REQ-012 Each btn_raw bit shall pass through a 2-flop synchronizer before any other logic.
REQ-013 Each bit shall have its own debounce counter, $clog2(DEBOUNCE_CYCLES+1) bits wide, cleared to 0 on any cycle where the synchronized input equals btn_db.
REQ-014 While the synchronized input differs from btn_db, the counter shall increment; on the edge where it would reach DEBOUNCE_CYCLES, btn_db shall toggle and the counter shall clear.
REQ-015 A raw level held stable from cycle t shall appear on btn_db in cycle t+DEBOUNCE_CYCLES+2; a shorter glitch shall never change btn_db.
REQ-016 right_move and left_move shall update only on the edge ending a cycle with fsync=1, from btn_db[0] and btn_db[1]; they shall hold between fsyncs.
REQ-017 If btn_db[0] and btn_db[1] are both 1 at the fsync sample, both right_move and left_move shall be 0.
REQ-018 A rising edge of btn_db[2] shall set a press_pending flag; the flag shall clear when a fire pulse is issued.
REQ-019 The fire FSM shall have states IDLE and HELD.
REQ-020 IDLE, fsync=1, press_pending or btn_db[2] set: assert fire_pulse the next cycle, clear repeat counter, go to HELD.
REQ-021 HELD, fsync=1, btn_db[2]=0: go to IDLE with no pulse, unless press_pending is set, in which case pulse and stay in HELD.
REQ-022 HELD, fsync=1, btn_db[2]=1, FIRE_REPEAT_FRAMES>0: increment repeat counter; when it reaches FIRE_REPEAT_FRAMES-1, pulse and clear the counter.
REQ-023 fire_pulse shall be high for exactly one cycle and never in two consecutive cycles; at most one fire pulse per frame.
REQ-024 ready_up_pulse shall be high for exactly the one cycle after a btn_db[3] rising edge, independent of fsync; holding the button yields one pulse only.
REQ-025 A button press coinciding with fsync shall be sampled per REQ-016/020 using the btn_db value present in that cycle.

Reset
REQ-026 On rst assertion, all outputs, synchronizer flops, counters and press_pending shall clear to 0 immediately, and the FSM shall go to IDLE.
REQ-027 After rst deasserts, buttons already held shall be treated as new presses: they debounce from 0 per REQ-015.
REQ-028 rst asserted mid-debounce shall discard the partial count; no pulse in progress shall complete.

Verification (DEBOUNCE_CYCLES=4, FIRE_REPEAT_FRAMES=3, fsync every 100 cycles)
REQ-029 btn_raw[0] high from cycle 10 -> btn_db[0]=1 at cycle 16; right_move=1 after the next fsync edge; left_move stays 0.
REQ-030 btn_raw[2] 3-cycle glitch -> btn_db[2] stays 0, no fire_pulse.
REQ-031 Fire held for 10 frames -> pulses after frames 1, 4, 7, 10; exactly one cycle each.
REQ-032 Fire pressed and released entirely between two fsyncs -> exactly one fire_pulse after the next fsync.
REQ-033 Right and left both held -> right_move=left_move=0; releasing left -> right_move=1 after the next fsync.
REQ-034 ready_up held 500 cycles -> one ready_up_pulse; rst mid-hold -> all outputs 0 at once, then one new pulse 6 cycles after rst release.

Source files
------------

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Turns four raw, asynchronous push buttons into clean game-control signals.
// Each button is synchronized, then debounced by a per-bit counter. The
// debounced levels drive frame-aligned paddle commands, a frame-aligned fire
// pulse with auto-repeat while held, and a one-shot ready-up pulse.
//
// Parameters
//   DEBOUNCE_CYCLES     cycles a synchronized input must disagree with its
//                       debounced state before that state flips (1..2^20)
//   FIRE_REPEAT_FRAMES  frames between auto-repeat fire pulses; 0 disables
//
// Ports
//   pixel_clk       in   sole clock
//   rst             in   asynchronous active-high reset
//   fsync           in   one-cycle frame-start pulse
//   btn_raw[3:0]    in   raw buttons: [0] right, [1] left, [2] fire, [3] ready_up
//   right_move      out  right command, updated only at fsync
//   left_move       out  left command, updated only at fsync
//   fire_pulse      out  one-cycle fire request, at most one per frame
//   ready_up_pulse  out  one-cycle pulse on each debounced ready_up press
//   btn_db[3:0]     out  debounced button levels
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES    = 20000,
    parameter int FIRE_REPEAT_FRAMES = 15
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic [3:0] btn_raw,
    output logic       right_move,
    output logic       left_move,
    output logic       fire_pulse,
    output logic       ready_up_pulse,
    output logic [3:0] btn_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int REP_W = (FIRE_REPEAT_FRAMES > 1) ? $clog2(FIRE_REPEAT_FRAMES) : 1;
    localparam logic [REP_W-1:0] REP_LAST =
        (FIRE_REPEAT_FRAMES > 0) ? REP_W'(FIRE_REPEAT_FRAMES - 1) : '0;

    typedef enum logic {
        IDLE,
        HELD
    } fire_state_t;

    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       db_q, db_d;
    logic [3:0]       toggle;
    logic [3:0]       rise;

    fire_state_t      state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             pending_q, pending_d;
    logic             fire_q, fire_d;
    logic             right_q, right_d;
    logic             left_q, left_d;
    logic             ready_q, ready_d;

    // Debounce: a bit flips on the edge where its disagreement count would
    // reach DEBOUNCE_CYCLES; any agreeing cycle throws the count away.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        db_d = db_q ^ toggle;
        rise = toggle & ~db_q;
    end

    // Fire FSM plus frame-sampled paddle commands. Everything here acts on
    // the btn_db value present in the fsync cycle itself.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        fire_d  = 1'b0;
        right_d = right_q;
        left_d  = left_q;

        if (fsync) begin
            // Opposing directions cancel rather than favouring one side.
            right_d = db_q[0] & ~db_q[1];
            left_d  = db_q[1] & ~db_q[0];

            case (state_q)
                IDLE: begin
                    if (pending_q || db_q[2]) begin
                        fire_d  = 1'b1;
                        rep_d   = '0;
                        state_d = HELD;
                    end
                end
                HELD: begin
                    // A fresh press seen since the last pulse always fires,
                    // whether or not the button is still down.
                    if (pending_q) begin
                        fire_d = 1'b1;
                        rep_d  = '0;
                    end else if (!db_q[2]) begin
                        state_d = IDLE;
                    end else if (FIRE_REPEAT_FRAMES > 0) begin
                        if (rep_q == REP_LAST) begin
                            fire_d = 1'b1;
                            rep_d  = '0;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new press landing on the same edge as a pulse stays pending.
        pending_d = rise[2] | (pending_q & ~fire_d);
        ready_d   = rise[3];
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            db_q      <= '0;
            state_q   <= IDLE;
            rep_q     <= '0;
            pending_q <= 1'b0;
            fire_q    <= 1'b0;
            right_q   <= 1'b0;
            left_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            state_q   <= state_d;
            rep_q     <= rep_d;
            pending_q <= pending_d;
            fire_q    <= fire_d;
            right_q   <= right_d;
            left_q    <= left_d;
            ready_q   <= ready_d;
        end
    end

    assign btn_db         = db_q;
    assign right_move     = right_q;
    assign left_move      = left_q;
    assign fire_pulse     = fire_q;
    assign ready_up_pulse = ready_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Drives input_conditioner with DEBOUNCE_CYCLES=4, FIRE_REPEAT_FRAMES=3 and an
// fsync every 100 cycles. A behavioural model (raw-input delay line, streak
// counts of disagreeing samples, a held flag and a frames-since-last-pulse
// count) predicts every output each cycle; directed scenarios add explicit
// latency and pulse-count expectations.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int D     = 4;
    localparam int R     = 3;
    localparam int FRAME = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       fsync;
    logic [3:0] btnRaw;
    logic       rightMove, leftMove, firePulse, readyPulse;
    logic [3:0] btnDb;
    logic [7:0] dutVec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state
    logic [3:0] mRawD1, mRawD2, mDb;
    int         mStreak [4];
    logic       mRight, mLeft, mFire, mReady, mHeld, mPending;
    int         mFrames;

    input_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .FIRE_REPEAT_FRAMES(R)
    ) dut (
        .pixel_clk     (clk),
        .rst           (rst),
        .fsync         (fsync),
        .btn_raw       (btnRaw),
        .right_move    (rightMove),
        .left_move     (leftMove),
        .fire_pulse    (firePulse),
        .ready_up_pulse(readyPulse),
        .btn_db        (btnDb)
    );

    assign dutVec = {rightMove, leftMove, firePulse, readyPulse, btnDb};

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("[TB] FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    function automatic void modelReset();
        mRawD1   = '0;
        mRawD2   = '0;
        mDb      = '0;
        for (int i = 0; i < 4; i++) mStreak[i] = 0;
        mRight   = 1'b0;
        mLeft    = 1'b0;
        mFire    = 1'b0;
        mReady   = 1'b0;
        mHeld    = 1'b0;
        mPending = 1'b0;
        mFrames  = 0;
    endfunction

    // Advances the model by one clock edge using the inputs of the cycle
    // that edge ends.
    function automatic void modelStep();
        logic [3:0] seen, newDb, risen;
        logic       fire;
        if (rst) begin
            modelReset();
            return;
        end
        seen  = mRawD2;
        newDb = mDb;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] != mDb[i]) begin
                mStreak[i]++;
                if (mStreak[i] == D) begin
                    newDb[i]   = ~mDb[i];
                    mStreak[i] = 0;
                end
            end else begin
                mStreak[i] = 0;
            end
        end
        risen = newDb & ~mDb;
        fire  = 1'b0;
        if (fsync) begin
            mRight = mDb[0] && !mDb[1];
            mLeft  = mDb[1] && !mDb[0];
            if (!mHeld) begin
                if (mPending || mDb[2]) begin
                    fire    = 1'b1;
                    mHeld   = 1'b1;
                    mFrames = 0;
                end
            end else if (mPending) begin
                fire    = 1'b1;
                mFrames = 0;
            end else if (!mDb[2]) begin
                mHeld = 1'b0;
            end else if (R > 0) begin
                mFrames++;
                if (mFrames == R) begin
                    fire    = 1'b1;
                    mFrames = 0;
                end
            end
        end
        mPending = risen[2] || (mPending && !fire);
        mReady   = risen[3];
        mFire    = fire;
        mDb      = newDb;
        mRawD2   = mRawD1;
        mRawD1   = btnRaw;
    endfunction

    function automatic logic [7:0] expVec();
        return {mRight, mLeft, mFire, mReady, mDb};
    endfunction

    // One clock: model follows the edge, outputs are then stable at +1.
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        cyc++;
        fsync = ((cyc % FRAME) == (FRAME - 1));
    endtask

    // Runs until the cycle just after an fsync cycle has ended.
    task automatic alignAfterFsync();
        for (int i = 0; i < FRAME + 1 && !fsync; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btnRaw = '0;
        fsync  = 1'b0;
        modelReset();
        #2;
        if (dutVec !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_async: outputs %b, expected %b", dutVec, 8'h00);
        end
        checks++;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dutVec !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_idle: cycle %0d outputs %b, expected %b", cyc, dutVec, 8'h00);
            end
            checks++;
        end
    endtask

    task automatic test_right();
        int lat = -1;
        btnRaw[0] = 1'b1;
        for (int n = 1; n <= 2 * FRAME; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL right_press: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
            if (btnDb[0] && lat < 0) lat = n;
        end
        if (lat != D + 2) begin
            errors++;
            $display("[TB] FAIL right_latency: took %0d cycles, expected %0d", lat, D + 2);
        end
        checks++;
        if (rightMove !== 1'b1 || leftMove !== 1'b0) begin
            errors++;
            $display("[TB] FAIL right_move: right=%b left=%b, expected right=1 left=0", rightMove, leftMove);
        end
        checks++;
        btnRaw[0] = 1'b0;
        for (int n = 0; n < FRAME + 10; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL right_release: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
        end
        if (rightMove !== 1'b0) begin
            errors++;
            $display("[TB] FAIL right_cleared: right=%b, expected 0", rightMove);
        end
        checks++;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int dbSeen = 0;
        btnRaw[2] = 1'b1;
        for (int n = 0; n < FRAME + 13; n++) begin
            if (n == 3) btnRaw[2] = 1'b0;
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL glitch: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
            if (firePulse) pulses++;
            if (btnDb[2]) dbSeen++;
        end
        if (pulses != 0 || dbSeen != 0) begin
            errors++;
            $display("[TB] FAIL glitch_ignored: pulses=%0d db_high=%0d, expected 0 and 0", pulses, dbSeen);
        end
        checks++;
    endtask

    task automatic test_fire_hold();
        int seen   = 0;
        int pulses = 0;
        alignAfterFsync();
        btnRaw[2] = 1'b1;
        for (int n = 0; n < 12 * FRAME && seen < 10; n++) begin
            if (fsync) seen++;
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL fire_hold: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
            if (firePulse) pulses++;
        end
        for (int n = 0; n < 2; n++) begin
            tick();
            if (firePulse) pulses++;
        end
        if (seen != 10 || pulses != 4) begin
            errors++;
            $display("[TB] FAIL fire_repeat: %0d pulses over %0d frames, expected 4 over 10", pulses, seen);
        end
        checks++;
        btnRaw[2] = 1'b0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL fire_release: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
        end
    endtask

    task automatic test_tap();
        int pulses = 0;
        alignAfterFsync();
        for (int n = 0; n < FRAME + 20; n++) begin
            if (n == 5)  btnRaw[2] = 1'b1;
            if (n == 15) btnRaw[2] = 1'b0;
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL tap: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
            if (firePulse) pulses++;
        end
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL tap_pulse: %0d pulses, expected 1", pulses);
        end
        checks++;
    endtask

    task automatic test_both();
        btnRaw[1:0] = 2'b11;
        for (int n = 0; n < 2 * FRAME; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL both_held: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
        end
        if (rightMove !== 1'b0 || leftMove !== 1'b0) begin
            errors++;
            $display("[TB] FAIL both_cancel: right=%b left=%b, expected 0 0", rightMove, leftMove);
        end
        checks++;
        btnRaw[1] = 1'b0;
        for (int n = 0; n < FRAME + 10; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL left_release: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
        end
        if (rightMove !== 1'b1 || leftMove !== 1'b0) begin
            errors++;
            $display("[TB] FAIL right_after_left: right=%b left=%b, expected 1 0", rightMove, leftMove);
        end
        checks++;
        btnRaw = '0;
        for (int n = 0; n < FRAME + 10; n++) tick();
    endtask

    task automatic test_ready_reset();
        int pulses = 0;
        int lat    = -1;
        btnRaw[3] = 1'b1;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL ready_hold: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
            if (readyPulse) pulses++;
        end
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL ready_once: %0d pulses, expected 1", pulses);
        end
        checks++;
        rst = 1'b1;
        modelReset();
        #1;
        if (dutVec !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_midhold: outputs %b, expected %b", dutVec, 8'h00);
        end
        checks++;
        for (int n = 0; n < 3; n++) tick();
        rst    = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL ready_after_reset: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
            if (readyPulse) begin
                pulses++;
                if (lat < 0) lat = n;
            end
        end
        if (lat != D + 2 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL ready_repress: latency %0d pulses %0d, expected %0d and 1", lat, pulses, D + 2);
        end
        checks++;
        btnRaw[3] = 1'b0;
        for (int n = 0; n < 20; n++) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) btnRaw[b] = ~btnRaw[b];
            end
            rst = ($urandom_range(0, 499) == 0);
            if (rst) modelReset();
            tick();
            if (dutVec !== expVec()) begin
                errors++;
                $display("[TB] FAIL random: cycle %0d got %b expected %b", cyc, dutVec, expVec());
            end
            checks++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_right();
        test_glitch();
        test_fire_hold();
        test_tap();
        test_both();
        test_ready_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
